// File: rtl/coin_accumulator.sv
// coin_accumulator
// Credit-accumulation stage that sits in front of main_controller. It validates
// and sums inserted coins against the price of the selected item. It raises
// currency_avail once the credit covers the price and holds it until
// dispense_enable arrives. It then pays out change, or refunds the whole credit
// on cancel, on timeout, or when the machine enters config mode.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   cfg_mode        machine in configuration mode (no vending, forces refund)
//   price_valid     one-cycle pulse: new selection, price is valid
//   price           price of the selected item
//   coin_valid      one-cycle pulse: a coin was detected
//   coin_type       denomination code (3 = invalid)
//   cancel          customer cancel pulse
//   dispense_enable item committed by main_controller
//   currency_avail  credit covers price (high while PAID)
//   credit          accumulated credit
//   coin_reject     one-cycle pulse: last coin returned, not credited
//   change_valid    one-cycle pulse: change_amount is to be paid out
//   change_amount   amount to return, valid with change_valid
module coin_accumulator #(
  parameter int CREDIT_W    = 8,
  parameter int COIN0_VAL   = 5,
  parameter int COIN1_VAL   = 10,
  parameter int COIN2_VAL   = 25,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_mode,
  input  logic                price_valid,
  input  logic [CREDIT_W-1:0] price,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  input  logic                dispense_enable,
  output logic                currency_avail,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAID    = 2'd2,
    PAYOUT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                avail_q, avail_d;
  logic                reject_q, reject_d;
  logic                chg_vld_q, chg_vld_d;
  logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;

  logic [CREDIT_W:0]   sum;
  logic                coin_ok;

  // Value of a coin code, one bit wider than credit so the sum cannot wrap.
  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] t);
    case (t)
      2'd0:    coin_value = (CREDIT_W+1)'(COIN0_VAL);
      2'd1:    coin_value = (CREDIT_W+1)'(COIN1_VAL);
      2'd2:    coin_value = (CREDIT_W+1)'(COIN2_VAL);
      default: coin_value = '0;
    endcase
  endfunction

  // A coin is creditable only if it is a valid denomination and the new total
  // still fits in CREDIT_W bits (the total saturates by rejection, never wraps).
  function automatic logic coin_fits(input logic [1:0] t, input logic [CREDIT_W:0] s);
    coin_fits = (t != 2'd3) && !s[CREDIT_W];
  endfunction

  assign sum     = {1'b0, credit_q} + coin_value(coin_type);
  assign coin_ok = coin_valid && coin_fits(coin_type, sum);

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    price_d   = price_q;
    tmr_d     = '0;
    chg_amt_d = chg_amt_q;
    // Every coin is returned unless COLLECT explicitly accepts it below.
    reject_d  = coin_valid;

    case (state_q)
      IDLE: begin
        credit_d = '0;
        if (price_valid && !cfg_mode) begin
          price_d = price;
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (cancel || cfg_mode) begin
          // Refund wins over a simultaneous coin, which is returned.
          chg_amt_d = credit_q;
          state_d   = PAYOUT;
        end else begin
          if (coin_valid) begin
            if (coin_ok) begin
              credit_d = sum[CREDIT_W-1:0];
              reject_d = 1'b0;
            end
          end else if (tmr_q == TMR_LAST) begin
            chg_amt_d = credit_q;
            state_d   = PAYOUT;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
          // Covers both a paying coin and a zero price selected last cycle.
          if (state_d == COLLECT && credit_d >= price_q) begin
            state_d = PAID;
          end
        end
      end

      PAID: begin
        // A committed item is never refunded.
        if (dispense_enable) begin
          chg_amt_d = credit_q - price_q;
          state_d   = PAYOUT;
        end else if (cancel || cfg_mode) begin
          chg_amt_d = credit_q;
          state_d   = PAYOUT;
        end
      end

      PAYOUT: begin
        credit_d = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    avail_d   = (state_d == PAID);
    chg_vld_d = (state_d == PAYOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      price_q   <= '0;
      tmr_q     <= '0;
      avail_q   <= 1'b0;
      reject_q  <= 1'b0;
      chg_vld_q <= 1'b0;
      chg_amt_q <= '0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      price_q   <= price_d;
      tmr_q     <= tmr_d;
      avail_q   <= avail_d;
      reject_q  <= reject_d;
      chg_vld_q <= chg_vld_d;
      chg_amt_q <= chg_amt_d;
    end
  end

  assign currency_avail = avail_q;
  assign credit         = credit_q;
  assign coin_reject    = reject_q;
  assign change_valid   = chg_vld_q;
  assign change_amount  = chg_amt_q;

endmodule

// File: tb/tb_coin_accumulator.sv
module tb_coin_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_mode;
  logic       price_valid;
  logic [7:0] price;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic       dispense_enable;
  logic       currency_avail;
  logic [7:0] credit;
  logic       coin_reject;
  logic       change_valid;
  logic [7:0] change_amount;

  int tests = 0;
  int fails = 0;
  int unsigned exp_q[$];

  coin_accumulator #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .price_valid(price_valid),
    .price(price), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .dispense_enable(dispense_enable),
    .currency_avail(currency_avail), .credit(credit), .coin_reject(coin_reject),
    .change_valid(change_valid), .change_amount(change_amount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic select(input int unsigned p);
    price_valid = 1'b1;
    price       = 8'(p);
    tick();
    price_valid = 1'b0;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  // Payout scoreboard: every change_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (change_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL sb_unexpected_payout observed=%0d expected=none", change_amount);
      end else begin
        automatic int unsigned e = exp_q.pop_front();
        assert (change_amount === 8'(e)) else begin
          fails++;
          $error("FAIL sb_payout observed=%0d expected=%0d", change_amount, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_mode = 1'b0; price_valid = 1'b0; price = '0;
    coin_valid = 1'b0; coin_type = '0; cancel = 1'b0; dispense_enable = 1'b0;
    tick(); tick();
    chk("rst_credit", credit, 0);
    chk("rst_avail", currency_avail, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_chg_vld", change_valid, 0);
    chk("rst_chg_amt", change_amount, 0);
    rst = 1'b0;
    tick();

    // Exact payment
    select(30);
    coin(2'd2);
    chk("exact_credit25", credit, 25);
    chk("exact_avail0", currency_avail, 0);
    coin(2'd0);
    chk("exact_credit30", credit, 30);
    chk("exact_avail1", currency_avail, 1);
    exp_q.push_back(0);
    dispense_enable = 1'b1; tick(); dispense_enable = 1'b0;
    chk("exact_chg_vld", change_valid, 1);
    chk("exact_chg_amt", change_amount, 0);
    chk("exact_avail_drop", currency_avail, 0);
    tick();
    chk("exact_credit_clr", credit, 0);
    chk("exact_chg_vld_end", change_valid, 0);

    // Overpay with change
    select(15);
    coin(2'd2);
    chk("over_avail", currency_avail, 1);
    exp_q.push_back(10);
    dispense_enable = 1'b1; tick(); dispense_enable = 1'b0;
    chk("over_chg_amt", change_amount, 10);
    tick();

    // Coin without selection, then invalid coin
    coin(2'd1);
    chk("idle_reject", coin_reject, 1);
    chk("idle_credit", credit, 0);
    tick();
    chk("reject_pulse_end", coin_reject, 0);
    select(20);
    coin(2'd3);
    chk("inv_reject", coin_reject, 1);
    chk("inv_credit", credit, 0);
    exp_q.push_back(0);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("zero_refund_vld", change_valid, 1);
    tick();

    // Cancel refund
    select(50);
    coin(2'd1); coin(2'd1);
    chk("cancel_credit", credit, 20);
    exp_q.push_back(20);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("cancel_amt", change_amount, 20);
    tick();
    chk("cancel_idle_credit", credit, 0);

    // Config-mode refund, then selection ignored while in config mode
    select(50);
    coin(2'd1); coin(2'd1);
    exp_q.push_back(20);
    cfg_mode = 1'b1; tick();
    chk("cfg_amt", change_amount, 20);
    chk("cfg_vld", change_valid, 1);
    tick();
    select(10);
    cfg_mode = 1'b0;
    tick();
    coin(2'd0);
    chk("cfg_sel_ignored_reject", coin_reject, 1);
    chk("cfg_sel_ignored_credit", credit, 0);

    // Timeout refund exactly 8 cycles after the last coin
    select(100);
    coin(2'd0);
    chk("to_credit", credit, 5);
    exp_q.push_back(5);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), change_valid, 0);
    end
    tick();
    chk("to_vld", change_valid, 1);
    chk("to_amt", change_amount, 5);
    tick();

    // Saturation: credit never wraps
    select(255);
    for (int i = 0; i < 10; i++) coin(2'd2);
    chk("sat_credit250", credit, 250);
    chk("sat_avail0", currency_avail, 0);
    coin(2'd2);
    chk("sat_reject", coin_reject, 1);
    chk("sat_credit_hold", credit, 250);
    exp_q.push_back(250);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("sat_refund", change_amount, 250);
    tick();

    // Zero price goes to PAID one cycle after COLLECT entry
    select(0);
    chk("p0_avail_first", currency_avail, 0);
    tick();
    chk("p0_avail", currency_avail, 1);
    exp_q.push_back(0);
    dispense_enable = 1'b1; tick(); dispense_enable = 1'b0;
    tick();

    // Dispense and cancel in the same cycle: change, not full refund
    select(15);
    coin(2'd2);
    exp_q.push_back(10);
    dispense_enable = 1'b1; cancel = 1'b1; tick();
    dispense_enable = 1'b0; cancel = 1'b0;
    chk("coll_amt", change_amount, 10);
    tick();

    // Reset mid-transaction discards credit with no payout
    select(50);
    coin(2'd0); coin(2'd1);
    chk("mid_credit", credit, 15);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_credit", credit, 0);
    chk("mid_rst_avail", currency_avail, 0);
    chk("mid_rst_reject", coin_reject, 0);
    chk("mid_rst_chg_vld", change_valid, 0);
    chk("mid_rst_chg_amt", change_amount, 0);
    tick();
    chk("mid_rst_no_payout", change_valid, 0);
    tick();

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coin_accumulator.md
# coin_accumulator

Credit-accumulation stage directly upstream of `main_controller`. It validates and sums inserted coins against the price of the selected item. It raises `currency_avail` once credit covers the price, and holds it until the controller's `dispense_enable` pulse arrives. It then returns change, or refunds the full credit on cancel, timeout or entry into config mode.

## Interface
Parameters:
- `CREDIT_W`, 8: width of credit, price and change values (unsigned).
- `COIN0_VAL`, 5: credit value of `coin_type` 0.
- `COIN1_VAL`, 10: credit value of `coin_type` 1.
- `COIN2_VAL`, 25: credit value of `coin_type` 2. `coin_type` 3 is invalid.
- `TIMEOUT_CYC`, 1000: idle cycles allowed in COLLECT before auto-refund (≥ 2).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg_mode`  in  1  machine in configuration mode; no vending.
- `price_valid`  in  1  one-cycle pulse: new selection, `price` is valid.
- `price`  in  CREDIT_W  price of the selected item.
- `coin_valid`  in  1  one-cycle pulse: a coin was detected.
- `coin_type`  in  2  denomination code of that coin.
- `cancel`  in  1  customer cancel request (pulse).
- `dispense_enable`  in  1  from `main_controller`: item committed.
- `currency_avail`  out  1  credit ≥ price; held high in PAID.
- `credit`  out  CREDIT_W  current accumulated credit.
- `coin_reject`  out  1  one-cycle pulse: last coin returned, not credited.
- `change_valid`  out  1  one-cycle pulse: `change_amount` to be paid out.
- `change_amount`  out  CREDIT_W  amount to return; valid while `change_valid` is high.

## Operation
States are IDLE, COLLECT, PAID and PAYOUT. All outputs are registered.
- **IDLE**
  - `credit` = 0.
  - `price_valid` with `cfg_mode` = 0: latch `price`, go to COLLECT.
  - Any coin pulses `coin_reject`; no selection means no credit.
- **COLLECT**
  - A valid coin adds its value to `credit`.
  - The coin is rejected if `coin_type` = 3, or if `credit` + value > 2^CREDIT_W−1. Credit is unchanged and the total never wraps.
  - If the new credit ≥ the latched price, go to PAID.
  - `price_valid` is ignored; the price stays locked once selected.
- **PAID**
  - `currency_avail` = 1. All coins are rejected.
  - `dispense_enable`: set `change_amount` = `credit` − price, go to PAYOUT.
- **PAYOUT**
  - Lasts one cycle. `change_valid` = 1; `change_amount` is held for that cycle.
  - All coins are rejected. Next state is IDLE with `credit` = 0.
- **Refund.** Any of the following in COLLECT or PAID sets `change_amount` = `credit` and goes to PAYOUT:
  - `cancel`;
  - `cfg_mode` = 1;
  - in COLLECT, TIMEOUT_CYC consecutive cycles with no `coin_valid`.
  - A zero refund still produces the PAYOUT cycle, with `change_amount` = 0.
- **Priority in PAID**, highest first: `dispense_enable`, then `cfg_mode` / `cancel`. A committed item is never refunded.
- **Priority in COLLECT**, highest first: `cfg_mode` / `cancel`, then coin, then timeout. A coin arriving in the same cycle as a cancel is rejected.
- **`cfg_mode` in IDLE:** `price_valid` is ignored and coins are rejected.
- **Price 0:** `price_valid` leads to COLLECT. The next cycle goes to PAID, since 0 ≥ 0.
- **Timeout counter:** clears on entry to COLLECT and on every accepted or rejected coin.

## Timing
- Reset values:
  - state = IDLE;
  - `credit` = 0, latched price = 0;
  - `currency_avail` = 0, `coin_reject` = 0, `change_valid` = 0, `change_amount` = 0;
  - timeout counter = 0.
- Reset asserted mid-transaction discards the credit with no payout. Reset overrides all inputs.
- `price_valid` at edge k: state is COLLECT at k+1.
- Coin sampled at edge k: `credit` is updated at k+1. If the price is met, `currency_avail` = 1 at k+1 as well.
- `coin_reject` is high during cycle k+1 only.
- `dispense_enable` at edge k: `currency_avail` = 0 and `change_valid` = 1 at k+1. State is IDLE and `credit` = 0 at k+2.
- The earliest new `price_valid` is accepted at edge k+2.
- Timeout: with the last coin (or COLLECT entry) at edge t, the refund enters PAYOUT at edge t+TIMEOUT_CYC.
- Inputs are sampled only on `clk`. A pulse held N cycles counts as N events.

## Test plan
- **Exact payment:** reset, then `price` = 30, then coins 25 and 5. Required: `credit` 25 → 30, `currency_avail` = 1 the cycle after the second coin. Then `dispense_enable` → `change_valid` = 1 with `change_amount` = 0, then `credit` = 0.
- **Overpay with change:** `price` = 15, then coin 25. Required: PAID; `dispense_enable` → `change_amount` = 10.
- **Coin without selection, and invalid coin:** coin type 1 in IDLE → `coin_reject` = 1, `credit` = 0. Then `price` = 20 and coin type 3 → rejected, `credit` stays 0.
- **Cancel and config refund:**
  - `price` = 50, coins 10 and 10, then `cancel` → `change_amount` = 20, then IDLE.
  - Repeat with `cfg_mode` = 1 in place of `cancel` → same refund. With `cfg_mode` held high, a following `price_valid` is ignored.
- **Timeout and saturation:**
  - With TIMEOUT_CYC = 8, `price` = 100 and coin 5 → refund of 5 exactly 8 cycles after the coin.
  - `price` = 255, then 10 coins of 25 (`credit` = 250), then a further 25 → rejected, `credit` stays 250.
- **Collision and reset:**
  - In PAID, `dispense_enable` and `cancel` in the same cycle → change = `credit` − price, not a full refund.
  - Separately, `rst` asserted in COLLECT with `credit` = 15 → all outputs return to their reset values the next cycle, with no `change_valid`.
